// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory port, IF/ID output register
// handshake, redirect inputs from execute, and status/counter outputs.
//   master : the fetch stage (drives imem_addr, IF/ID register, status)
//   slave  : the surrounding pipeline / memory / bench
interface fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm;
  logic        j_valid;
  logic [31:0] j_pc4;
  logic [25:0] j_index;
  logic        jr_valid;
  logic [31:0] jr_target;
  logic        halted;
  logic        misaligned;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    output imem_addr, if_valid, if_instr, if_pc, if_pc4,
           halted, misaligned, fetch_count, stall_count,
    input  imem_data, id_ready, br_taken, br_pc4, br_imm,
           j_valid, j_pc4, j_index, jr_valid, jr_target
  );

  modport slave (
    input  imem_addr, if_valid, if_instr, if_pc, if_pc4,
           halted, misaligned, fetch_count, stall_count,
    output imem_data, id_ready, br_taken, br_pc4, br_imm,
           j_valid, j_pc4, j_index, jr_valid, jr_target
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, presents it as the async imem address,
// and registers {instr, pc, pc+4} into a valid/ready IF/ID register.
// Redirects from execute (jr > j > br) flush the register and retarget the PC.
// A fetched HALT_INSTR parks the stage in HALTED until the next redirect.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : fetch_if.master (imem port, IF/ID register, redirects, status)
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_000C
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  typedef enum logic {FETCH, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        valid_q;
  logic [31:0] instr_q, pc_q, pc4_q;
  logic        mis_q;
  logic [31:0] fcnt_q, scnt_q;

  logic [31:0] br_tgt, j_tgt, target;
  logic        redirect, load;

  // Branch immediate is a word offset: sign-extend then scale by 4.
  assign br_tgt   = bus.br_pc4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign j_tgt    = {bus.j_pc4[31:28], bus.j_index, 2'b00};
  assign target   = bus.jr_valid ? bus.jr_target :
                    bus.j_valid  ? j_tgt : br_tgt;
  assign redirect = bus.jr_valid | bus.j_valid | bus.br_taken;
  // A slot opens when the register is empty or decode is taking it now.
  assign load     = !redirect && (state == FETCH) && (!valid_q || bus.id_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
      pc4_q   <= '0;
      mis_q   <= 1'b0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else if (redirect) begin
      // Flush wins over any pending handshake; low PC bits are dropped but
      // remembered in the sticky flag.
      pc      <= {target[31:2], 2'b00};
      valid_q <= 1'b0;
      state   <= FETCH;
      if (target[1:0] != 2'b00) mis_q <= 1'b1;
    end else if (load) begin
      instr_q <= bus.imem_data;
      pc_q    <= pc;
      pc4_q   <= pc + 32'd4;
      valid_q <= 1'b1;
      pc      <= pc + 32'd4;
      fcnt_q  <= fcnt_q + 32'd1;
      if (bus.imem_data == HALT_INSTR) state <= HALTED;
    end else if (valid_q) begin
      if (bus.id_ready) valid_q <= 1'b0;
      else              scnt_q  <= scnt_q + 32'd1;
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_pc       = pc_q;
  assign bus.if_pc4      = pc4_q;
  assign bus.halted      = (state == HALTED) && !valid_q;
  assign bus.misaligned  = mis_q;
  assign bus.fetch_count = fcnt_q;
  assign bus.stall_count = scnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  localparam logic [31:0] HALT = 32'h0000_000C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] halt_addr = 32'h1;  // unaligned: never matches a fetch PC
  int checks = 0;
  int failures = 0;

  fetch_if bus();
  fetch_stage #(.RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: scrambled address, except one address holding HALT.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
    logic [31:0] w;
    w = a ^ 32'hA5A5_0000;
    if (w == HALT) w = 32'h0000_000D;
    return (a == h) ? HALT : w;
  endfunction

  assign bus.imem_data = mem_word(bus.imem_addr, halt_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [31:0] m_pc, m_instr, m_ipc, m_pc4, m_fc, m_sc;
  logic        m_valid, m_halt, m_mis;

  always @(posedge clk or posedge reset) begin
    logic [31:0] tgt, w;
    if (reset) begin
      m_pc <= 0; m_instr <= 0; m_ipc <= 0; m_pc4 <= 0; m_fc <= 0; m_sc <= 0;
      m_valid <= 0; m_halt <= 0; m_mis <= 0;
    end else if (bus.jr_valid || bus.j_valid || bus.br_taken) begin
      if (bus.jr_valid)     tgt = bus.jr_target;
      else if (bus.j_valid) tgt = (bus.j_pc4 & 32'hF000_0000) + ({6'd0, bus.j_index} * 4);
      else                  tgt = bus.br_pc4 + 32'($signed(bus.br_imm)) * 4;
      m_pc    <= tgt & ~32'd3;
      m_valid <= 0;
      m_halt  <= 0;
      if (tgt % 4 != 0) m_mis <= 1;
    end else if (!m_halt && (!m_valid || bus.id_ready)) begin
      w = mem_word(m_pc, halt_addr);
      m_instr <= w; m_ipc <= m_pc; m_pc4 <= m_pc + 4;
      m_valid <= 1; m_pc <= m_pc + 4; m_fc <= m_fc + 1;
      if (w == HALT) m_halt <= 1;
    end else if (m_valid && !bus.id_ready) begin
      m_sc <= m_sc + 1;
    end else begin
      m_valid <= 0;
    end
  end

  // One compare process, every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("imem_addr",   bus.imem_addr, m_pc);
      check("if_valid",    32'(bus.if_valid), 32'(m_valid));
      if (m_valid) begin
        check("if_instr",  bus.if_instr, m_instr);
        check("if_pc",     bus.if_pc, m_ipc);
        check("if_pc4",    bus.if_pc4, m_pc4);
      end
      check("halted",      32'(bus.halted), 32'(m_halt && !m_valid));
      check("misaligned",  32'(bus.misaligned), 32'(m_mis));
      check("fetch_count", bus.fetch_count, m_fc);
      check("stall_count", bus.stall_count, m_sc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    bus.br_taken = 0; bus.j_valid = 0; bus.jr_valid = 0;
  endtask

  initial begin
    logic [31:0] saved;
    int r;
    bus.id_ready = 1; bus.br_pc4 = 0; bus.br_imm = 0; bus.j_pc4 = 0;
    bus.j_index = 0; bus.jr_target = 0;
    clr();
    cyc(2);
    check("rst_valid", 32'(bus.if_valid), 0);
    check("rst_pc", bus.if_pc, 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_fcnt", bus.fetch_count, 0);
    check("rst_mis", 32'(bus.misaligned), 0);
    reset = 0;

    // sequential fetch, one per cycle
    for (int k = 1; k <= 4; k++) begin
      cyc(1);
      check("seq_pc", bus.if_pc, 32'(4 * (k - 1)));
      check("seq_fcnt", bus.fetch_count, 32'(k));
    end

    // 3-cycle stall
    bus.id_ready = 0; cyc(3);
    check("stall_cnt", bus.stall_count, 3);
    check("stall_pc", bus.if_pc, 32'hC);
    check("stall_addr", bus.imem_addr, 32'h10);
    bus.id_ready = 1; cyc(1);
    check("after_stall_pc", bus.if_pc, 32'h10);

    // branch while stalled: 0x20 + (-4 << 2) = 0x10
    bus.id_ready = 0; cyc(1);
    bus.br_taken = 1; bus.br_pc4 = 32'h20; bus.br_imm = 16'hFFFC; cyc(1); clr();
    check("br_flush", 32'(bus.if_valid), 0);
    check("br_addr", bus.imem_addr, 32'h10);
    bus.id_ready = 1; cyc(1);
    check("br_pc", bus.if_pc, 32'h10);

    // jr beats j; then j alone
    bus.jr_valid = 1; bus.jr_target = 32'h400; bus.j_valid = 1;
    bus.j_pc4 = 32'h4000_0010; bus.j_index = 26'h100; cyc(1); clr();
    cyc(1);
    check("jr_prio_pc", bus.if_pc, 32'h400);
    bus.j_valid = 1; cyc(1); clr(); cyc(1);
    check("j_pc", bus.if_pc, 32'h4000_0400);

    // halt at 0x8
    halt_addr = 32'h8;
    bus.jr_valid = 1; bus.jr_target = 0; cyc(1); clr();
    cyc(3);
    check("halt_pc", bus.if_pc, 32'h8);
    check("halt_instr", bus.if_instr, HALT);
    cyc(1);
    check("halted", 32'(bus.halted), 1);
    check("halt_addr", bus.imem_addr, 32'hC);
    saved = m_fc;
    cyc(3);
    check("halt_noload", bus.fetch_count, saved);
    bus.jr_valid = 1; bus.jr_target = 32'h40; cyc(1); clr();
    halt_addr = 32'h1;
    cyc(1);
    check("unhalt_pc", bus.if_pc, 32'h40);
    check("unhalt_halted", 32'(bus.halted), 0);

    // misaligned jr
    bus.jr_valid = 1; bus.jr_target = 32'h103; cyc(1); clr();
    check("mis_addr", bus.imem_addr, 32'h100);
    check("mis_flag", 32'(bus.misaligned), 1);
    cyc(1);
    check("mis_pc", bus.if_pc, 32'h100);

    // PC wrap
    bus.jr_valid = 1; bus.jr_target = 32'hFFFF_FFF8; cyc(1); clr();
    cyc(2);
    check("wrap_pc4", bus.if_pc4, 0);
    cyc(1);
    check("wrap_pc", bus.if_pc, 0);

    // randomized traffic with halts at 0x40
    halt_addr = 32'h40;
    for (int i = 0; i < 3000; i++) begin
      cyc(1);
      bus.id_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      bus.jr_valid = (r == 0) || (r == 3);
      bus.j_valid  = (r == 1) || (r == 3);
      bus.br_taken = (r == 2) || (r == 3);
      bus.jr_target = 32'($urandom_range(0, 255)) &
                      (($urandom_range(0, 7) == 0) ? 32'hFF : 32'hFC);
      bus.br_pc4 = 32'($urandom_range(0, 63)) * 4;
      bus.br_imm = 16'($urandom_range(0, 15)) - 16'd8;
      bus.j_pc4 = $urandom;
      bus.j_index = 26'($urandom_range(0, 63));
    end

    // async reset mid-stall
    cyc(1); clr(); halt_addr = 32'h1; bus.id_ready = 1;
    bus.jr_valid = 1; bus.jr_target = 0; cyc(1); clr();
    cyc(2); bus.id_ready = 0; cyc(2);
    check("pre_rst_valid", 32'(bus.if_valid), 1);
    #2 reset = 1;
    #1;
    check("arst_valid", 32'(bus.if_valid), 0);
    check("arst_pc", bus.if_pc, 0);
    check("arst_instr", bus.if_instr, 0);
    check("arst_addr", bus.imem_addr, 0);
    check("arst_fcnt", bus.fetch_count, 0);
    check("arst_scnt", bus.stall_count, 0);
    check("arst_mis", 32'(bus.misaligned), 0);
    cyc(2);
    reset = 0; bus.id_ready = 1;
    cyc(5);
    check("post_rst_pc", bus.if_pc, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
